// File: rtl/fifo_sram_buffer_pkg.sv
// fifo_sram_buffer_pkg
// Shared constants for the packet buffer: default word/address widths,
// derived depth and pointer/count widths, almost-full margin, and the
// ctrl/data field boundaries of a 72-bit word.
package fifo_sram_buffer_pkg;

  localparam int unsigned DWIDTH_DEF    = 72;
  localparam int unsigned IAWIDTH_DEF   = 10;
  localparam int unsigned DEPTH_DEF     = 1 << IAWIDTH_DEF;
  localparam int unsigned PTR_W_DEF     = IAWIDTH_DEF;
  localparam int unsigned CNT_W_DEF     = IAWIDTH_DEF + 1;
  localparam int unsigned AF_MARGIN_DEF = 4;

  localparam int unsigned CTRL_MSB = 71;
  localparam int unsigned CTRL_LSB = 64;

  // Extract the 8-bit ctrl field of a buffer word.
  function automatic logic [CTRL_MSB-CTRL_LSB:0] ctrl_of(input logic [DWIDTH_DEF-1:0] w);
    return w[CTRL_MSB:CTRL_LSB];
  endfunction

endpackage

// File: rtl/fifo_sram_buffer_sram_dp.sv
// sram_dp
// Dual-port synchronous RAM, read-first, one write port per side.
// Side A has independent write and read addresses (FIFO tail / FIFO head);
// side B has a single read/write address (processor window).
// Ports:
//   i_clk, i_rst           clock, async active-high reset (output regs only)
//   i_we_a/i_waddr_a/i_din_a   side A write
//   i_re_a/i_raddr_a/o_dout_a  side A read, output holds when i_re_a=0
//   i_we_b/i_addr_b/i_din_b    side B write
//   o_dout_b                   side B read, updated every cycle
module sram_dp #(
  parameter int unsigned DWIDTH  = 72,
  parameter int unsigned IAWIDTH = 10
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_we_a,
  input  logic [IAWIDTH-1:0] i_waddr_a,
  input  logic [DWIDTH-1:0]  i_din_a,
  input  logic               i_re_a,
  input  logic [IAWIDTH-1:0] i_raddr_a,
  output logic [DWIDTH-1:0]  o_dout_a,
  input  logic               i_we_b,
  input  logic [IAWIDTH-1:0] i_addr_b,
  input  logic [DWIDTH-1:0]  i_din_b,
  output logic [DWIDTH-1:0]  o_dout_b
);

  localparam int unsigned DEPTH = 1 << IAWIDTH;

  logic [DWIDTH-1:0] r_mem [DEPTH];

  // Side B is written last so it wins when both sides hit one address.
  always_ff @(posedge i_clk) begin
    if (i_we_a) r_mem[i_waddr_a] <= i_din_a;
    if (i_we_b) r_mem[i_addr_b]  <= i_din_b;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_dout_a <= '0;
      o_dout_b <= '0;
    end else begin
      if (i_re_a) o_dout_a <= r_mem[i_raddr_a];
      o_dout_b <= r_mem[i_addr_b];
    end
  end

endmodule

// File: rtl/fifo_sram_buffer.sv
// fifo_sram_buffer
// Packet buffer: one dual-port SRAM used as a FIFO (side A) and as the
// processor's window relative to the FIFO head (side B). While pc_en is
// high the FIFO is frozen (stall) so the processor can edit queued words.
// Optional macro: FIFO_HOST_PORT_EN -- when defined, wea during stall
// writes dina to absolute address addra without touching pointers/count.
// Ports:
//   clk, reset                 clock, async active-high reset
//   pc_en                      processor enable (freezes FIFO)
//   wea, fifo_input            FIFO write strobe / data
//   addra, dina                host absolute write (macro only)
//   reb, fifo_output           FIFO read strobe / registered data
//   web, addrb, dinb           processor write, address relative to head
//   sram_data_out              processor read data, registered
//   almfull, fifo_empty, stall status flags
module fifo_sram_buffer
  import fifo_sram_buffer_pkg::*;
#(
  parameter int unsigned DWIDTH    = DWIDTH_DEF,
  parameter int unsigned IAWIDTH   = IAWIDTH_DEF,
  parameter int unsigned AF_MARGIN = AF_MARGIN_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pc_en,
  input  logic               wea,
  input  logic [IAWIDTH-1:0] addra,
  input  logic [DWIDTH-1:0]  dina,
  input  logic [DWIDTH-1:0]  fifo_input,
  input  logic               reb,
  output logic [DWIDTH-1:0]  fifo_output,
  input  logic               web,
  input  logic [IAWIDTH-1:0] addrb,
  input  logic [DWIDTH-1:0]  dinb,
  output logic [DWIDTH-1:0]  sram_data_out,
  output logic               almfull,
  output logic               fifo_empty,
  output logic               stall
);

  localparam int unsigned DEPTH = 1 << IAWIDTH;
  localparam int unsigned CW    = IAWIDTH + 1;

  logic [IAWIDTH-1:0] r_wr_ptr;
  logic [IAWIDTH-1:0] r_rd_ptr;
  logic [CW-1:0]      r_count;

  logic               w_full;
  logic               w_wr_acc;
  logic               w_rd_acc;
  logic [IAWIDTH-1:0] w_ea;
  logic               w_a_we;
  logic [IAWIDTH-1:0] w_a_addr;
  logic [DWIDTH-1:0]  w_a_din;

  assign stall      = pc_en;
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_wr_acc   = wea & ~stall & ~w_full;
  assign w_rd_acc   = reb & ~stall & (r_count != '0);
  assign w_ea       = r_rd_ptr + addrb;
  assign fifo_empty = (r_count == '0);
  assign almfull    = ((CW'(DEPTH) - r_count) <= CW'(AF_MARGIN));

`ifdef FIFO_HOST_PORT_EN
  // During stall the side-A write port is lent to the host at an
  // absolute address; otherwise it serves the FIFO tail.
  always_comb begin
    w_a_we   = w_wr_acc;
    w_a_addr = r_wr_ptr;
    w_a_din  = fifo_input;
    if (stall && wea) begin
      w_a_we   = 1'b1;
      w_a_addr = addra;
      w_a_din  = dina;
    end
  end
`else
  logic w_unused_host;
  assign w_unused_host = ^{addra, dina};

  always_comb begin
    w_a_we   = w_wr_acc;
    w_a_addr = r_wr_ptr;
    w_a_din  = fifo_input;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  sram_dp #(
    .DWIDTH (DWIDTH),
    .IAWIDTH(IAWIDTH)
  ) u_sram (
    .i_clk    (clk),
    .i_rst    (reset),
    .i_we_a   (w_a_we),
    .i_waddr_a(w_a_addr),
    .i_din_a  (w_a_din),
    .i_re_a   (w_rd_acc),
    .i_raddr_a(r_rd_ptr),
    .o_dout_a (fifo_output),
    .i_we_b   (web),
    .i_addr_b (w_ea),
    .i_din_b  (dinb),
    .o_dout_b (sram_data_out)
  );

endmodule

// File: tb/tb_fifo_sram_buffer.sv
// tb_fifo_sram_buffer
// Directed + randomized bench for fifo_sram_buffer against an array/queue
// style reference model (head index + occupancy, absolute memory image).
// Honours FIFO_HOST_PORT_EN when defined.
module tb_fifo_sram_buffer;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_en;
  logic        wea;
  logic [9:0]  addra;
  logic [71:0] dina;
  logic [71:0] fifo_input;
  logic        reb;
  logic [71:0] fifo_output;
  logic        web;
  logic [9:0]  addrb;
  logic [71:0] dinb;
  logic [71:0] sram_data_out;
  logic        almfull;
  logic        fifo_empty;
  logic        stall;

  always #5 clk = ~clk;

  fifo_sram_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .pc_en        (pc_en),
    .wea          (wea),
    .addra        (addra),
    .dina         (dina),
    .fifo_input   (fifo_input),
    .reb          (reb),
    .fifo_output  (fifo_output),
    .web          (web),
    .addrb        (addrb),
    .dinb         (dinb),
    .sram_data_out(sram_data_out),
    .almfull      (almfull),
    .fifo_empty   (fifo_empty),
    .stall        (stall)
  );

  // Reference model
  logic [71:0] m_mem [DEPTH];
  bit          m_val [DEPTH];
  int          m_head = 0;
  int          m_cnt  = 0;
  logic [71:0] m_fo   = '0;
  logic [71:0] m_sdo  = '0;
  bit          m_sdo_val = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [71:0] rnd72();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[71:0];
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance one clock: update the model from the current inputs, then
  // compare all visible state 1 time unit after the edge.
  task automatic cycle();
    int ea, wpos;
    bit wacc, racc;
    logic [71:0] nfo;
    wacc = wea && !pc_en && (m_cnt != DEPTH);
    racc = reb && !pc_en && (m_cnt != 0);
    ea   = (m_head + int'(addrb)) % DEPTH;
    m_sdo     = m_mem[ea];
    m_sdo_val = m_val[ea];
    nfo  = racc ? m_mem[m_head] : m_fo;
    wpos = (m_head + m_cnt) % DEPTH;
    if (wacc) begin m_mem[wpos] = fifo_input; m_val[wpos] = 1'b1; end
`ifdef FIFO_HOST_PORT_EN
    if (wea && pc_en) begin m_mem[addra] = dina; m_val[addra] = 1'b1; end
`endif
    if (web) begin m_mem[ea] = dinb; m_val[ea] = 1'b1; end
    if (racc) m_head = (m_head + 1) % DEPTH;
    m_cnt = m_cnt + int'(wacc) - int'(racc);
    m_fo  = nfo;
    @(posedge clk); #1;
    chk("fifo_output", fifo_output, m_fo);
    if (m_sdo_val) chk("sram_data_out", sram_data_out, m_sdo);
    chk("fifo_empty", 72'(fifo_empty), 72'(m_cnt == 0));
    chk("almfull", 72'(almfull), 72'((DEPTH - m_cnt) <= 4));
    chk("count", 72'(dut.r_count), 72'(m_cnt));
  endtask

  task automatic idle();
    wea = 1'b0; reb = 1'b0; web = 1'b0;
  endtask

  initial begin
    logic [71:0] wa, wb, wc, old5, exp5;
    reset = 1'b1; pc_en = 1'b0; wea = 1'b0; reb = 1'b0; web = 1'b0;
    addra = '0; dina = '0; fifo_input = '0; addrb = '0; dinb = '0;

    // Reset values
    #1;
    chk("rst_fifo_output", fifo_output, 72'h0);
    chk("rst_sram_data_out", sram_data_out, 72'h0);
    chk("rst_fifo_empty", 72'(fifo_empty), 72'(1));
    chk("rst_almfull", 72'(almfull), 72'(0));
    chk("rst_stall", 72'(stall), 72'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Read while empty: rejected
    reb = 1'b1;
    cycle();
    chk("empty_rd_ptr", 72'(dut.r_rd_ptr), 72'(0));
    idle();

    // Five words in, five out in order
    wea = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      fifo_input = 72'(i);
      cycle();
      if (i == 1) chk("empty_fall", 72'(fifo_empty), 72'(0));
    end
    idle(); reb = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      chk("rd5_data", fifo_output, 72'(i));
    end
    idle();
    cycle();
    chk("rd5_empty", 72'(fifo_empty), 72'(1));

    // Fill past full (last 3 dropped), drain across the pointer wrap
    wea = 1'b1;
    for (int i = 0; i < 1027; i++) begin
      fifo_input = 72'(i);
      cycle();
      if (i == 1019) chk("almfull_at_1020", 72'(almfull), 72'(1));
      if (i == 1018) chk("almfull_at_1019", 72'(almfull), 72'(0));
    end
    idle(); reb = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      cycle();
      chk("drain_data", fifo_output, 72'(i));
    end
    idle();
    cycle();

    // Processor window over A, B, C
    wa = rnd72(); wb = rnd72(); wc = rnd72();
    wea = 1'b1;
    fifo_input = wa; cycle();
    fifo_input = wb; cycle();
    fifo_input = wc; cycle();
    pc_en = 1'b1; reb = 1'b1; fifo_input = rnd72();
    addra = 10'((m_head + 500) % DEPTH); dina = rnd72();
    addrb = 10'd1;
    #1 chk("stall_high", 72'(stall), 72'(1));
    cycle();
    chk("portB_B", sram_data_out, wb);
    idle();
    web = 1'b1; dinb = '1;
    cycle();
    chk("portB_readfirst", sram_data_out, wb);
    idle(); pc_en = 1'b0;
    #1 chk("stall_low", 72'(stall), 72'(0));
    reb = 1'b1;
    cycle(); chk("pc_rd_A", fifo_output, wa);
    cycle(); chk("pc_rd_mod", fifo_output, '1);
    cycle(); chk("pc_rd_C", fifo_output, wc);
    idle();

    // Host port: absolute write of mem[5] while stalled
    old5 = m_mem[5];
`ifdef FIFO_HOST_PORT_EN
    exp5 = 72'h12;
`else
    exp5 = old5;
`endif
    pc_en = 1'b1; wea = 1'b1; addra = 10'd5; dina = 72'h12; addrb = '0;
    cycle();
    wea = 1'b0;
    addrb = 10'((5 - m_head + DEPTH) % DEPTH);
    cycle();
    chk("host_mem5", sram_data_out, exp5);
    chk("host_count", 72'(dut.r_count), 72'(0));
    pc_en = 1'b0;

    // Steady state: concurrent write+read with 10 queued
    wea = 1'b1;
    for (int i = 0; i < 10; i++) begin fifo_input = rnd72(); cycle(); end
    reb = 1'b1;
    for (int i = 0; i < 100; i++) begin fifo_input = rnd72(); cycle(); end
    chk("concurrent_count", 72'(dut.r_count), 72'(10));
    idle();

    // Random mix of everything
    for (int i = 0; i < 400; i++) begin
      pc_en      = ($urandom % 4) == 0;
      wea        = ($urandom % 2) == 0;
      reb        = ($urandom % 2) == 0;
      web        = ($urandom % 8) == 0;
      addrb      = 10'($urandom % 16);
      addra      = 10'($urandom);
      dina       = rnd72();
      dinb       = rnd72();
      fifo_input = rnd72();
      cycle();
    end
    idle(); pc_en = 1'b0;

    // Reset mid-operation: FIFO empties, memory retained
    wea = 1'b1;
    for (int i = 0; i < 3; i++) begin fifo_input = rnd72(); cycle(); end
    idle();
    reset = 1'b1;
    #1;
    m_head = 0; m_cnt = 0; m_fo = '0; m_sdo = '0; m_sdo_val = 1'b0;
    chk("midrst_empty", 72'(fifo_empty), 72'(1));
    chk("midrst_fifo_output", fifo_output, 72'h0);
    chk("midrst_sram_data_out", sram_data_out, 72'h0);
    chk("midrst_count", 72'(dut.r_count), 72'(0));
    @(posedge clk); #1 reset = 1'b0;
    addrb = '0;
    cycle();
    chk("midrst_mem0", sram_data_out, m_mem[0]);
    reb = 1'b1;
    cycle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_sram_buffer.md
# fifo_sram_buffer

Packet buffer for the network datapath. A single dual-port SRAM is used as a FIFO on port A and the processor's data window on port B. Incoming 72-bit words (8-bit ctrl + 64-bit data) are queued and drained to the output path. While the processor is enabled, the FIFO freezes so the processor core can read and modify the words at the head of the queue in place.

## Interface
- DWIDTH, 72, word width (ctrl in [71:64], data in [63:0])
- IAWIDTH, 10, address width; depth = 2^IAWIDTH (1024)
- AF_MARGIN, 4, `almfull` asserts when free entries ≤ AF_MARGIN
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- pc_en  in  1  processor enable; freezes FIFO while high
- wea  in  1  FIFO write strobe
- addra  in  IAWIDTH  host absolute write address (see Configuration)
- dina  in  DWIDTH  host write data (see Configuration)
- fifo_input  in  DWIDTH  FIFO write data
- reb  in  1  FIFO read strobe
- fifo_output  out  DWIDTH  FIFO read data, registered
- web  in  1  processor write strobe
- addrb  in  IAWIDTH  processor address, relative to FIFO head
- dinb  in  DWIDTH  processor write data
- sram_data_out  out  DWIDTH  processor read data, registered
- almfull  out  1  almost full
- fifo_empty  out  1  count == 0
- stall  out  1  FIFO frozen (equals pc_en)

## Operation
- State:
  - wr_ptr, rd_ptr: IAWIDTH bits each.
  - count: IAWIDTH+1 bits.
  - Storage array.
- Write acceptance: a write is accepted when wea & ~stall & (count != DEPTH). It stores fifo_input at wr_ptr and increments wr_ptr.
  - A write while full or stalled is dropped silently.
- Read acceptance: a read is accepted when reb & ~stall & (count != 0).
  - fifo_output <= mem[rd_ptr], and rd_ptr increments.
  - If no read is accepted, fifo_output holds its value.
- Simultaneous accepted read and write: count is unchanged.
  - A read of a word written in the same cycle is not possible, because count was 0 and the read is rejected.
- Pointers wrap modulo 2^IAWIDTH.
- stall = pc_en, combinational.
- Processor port B (any time):
  - Effective address ea = (rd_ptr + addrb) mod DEPTH.
  - sram_data_out <= mem[ea] every cycle.
  - If web = 1, mem[ea] <= dinb. Read-first: sram_data_out shows the old data.
  - web has priority over a FIFO write to the same address in the same cycle.
- Flags:
  - fifo_empty = (count == 0).
  - almfull = (DEPTH − count ≤ AF_MARGIN).
  - Both are combinational from count.

## Timing
- Reset values:
  - Pointers, count: 0.
  - fifo_output: 0.
  - sram_data_out: 0.
  - fifo_empty: 1.
  - almfull: 0.
  - stall follows pc_en.
- Write to fifo_empty falling: 1 cycle.
- Read latency: data valid on fifo_output 1 cycle after the accepted reb.
- Port B read latency: 1 cycle.
- stall takes effect in the same cycle pc_en rises. FIFO operations resume in the cycle pc_en falls.
- Reset asserted mid-operation empties the FIFO immediately. Memory contents are not cleared.

## Configuration
- FIFO_HOST_PORT_EN defined:
  - When stall = 1 and wea = 1, mem[addra] <= dina at an absolute address. Pointers and count are unchanged.
  - port B web still wins on an address collision.
- FIFO_HOST_PORT_EN undefined: addra and dina are ignored.

## Structure
- Shared package holds:
  - DWIDTH/IAWIDTH defaults.
  - DEPTH = 1 << IAWIDTH.
  - Pointer/count widths.
  - AF_MARGIN default.
  - Field slices CTRL_MSB = 71, CTRL_LSB = 64.
- One sub-module, `sram_dp`: a true dual-port synchronous RAM, read-first, one write port per side. The top-level holds the pointers, count, flags and port muxing.

## Test plan
- After reset: fifo_empty=1, almfull=0, fifo_output=0. A reb with an empty FIFO leaves the pointers at 0.
- Write 0x00_0000000000000001..0x05: fifo_empty falls 1 cycle after the first write. Reading 5 words returns the values in order, each 1 cycle after reb, then fifo_empty=1.
- Write 1020 words: almfull=1 at count 1020. Writes 1025+ are dropped. Draining all returns the values 0..1023 in order across the pointer wrap.
- Preload 3 words A, B, C, then raise pc_en:
  - stall=1, and wea/reb are ignored.
  - addrb=1 gives sram_data_out=B next cycle.
  - web with addrb=1 and dinb=0xFF..FF, then drop pc_en and read 3 words: A, 0xFF..FF, C.
- Concurrent wea and reb for 100 cycles with count 10: count stays 10 and the data order is preserved.
- FIFO_HOST_PORT_EN defined: with pc_en=1, wea=1, addra=5, dina=0x12 gives mem[5]=0x12 and count unchanged. Undefined: mem[5] is unchanged.
